pc_address_unit: RTL

//  Program counter plus address-bus source mux, directly downstream of instruction_decode.

---
 rtl/pc_address_unit_if.sv | 28 ++
 rtl/pc_address_unit.sv | 98 +++++++++
 2 files changed

// File: rtl/pc_address_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_address_unit_if
// Description : Decoder-side bus between instruction_decode and pc_address_unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_address_unit_if;
    logic        clk_enable;
    logic [2:0]  pc_enable;
    logic [1:0]  address_select;
    logic [15:0] memory_address;
    logic [7:0]  alu_result;
    logic [7:0]  data_in;
    logic [15:0] address_out;
    logic [15:0] pc_out;
    logic        busy;

    modport master (
        output clk_enable, pc_enable, address_select, memory_address, alu_result, data_in,
        input  address_out, pc_out, busy
    );

    modport slave (
        input  clk_enable, pc_enable, address_select, memory_address, alu_result, data_in,
        output address_out, pc_out, busy
    );
endinterface
`default_nettype wire

// File: rtl/pc_address_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_address_unit
// Description : Program counter and address-bus source mux. Optional 6502
//               reset-vector fetch enabled by defining RESET_VECTOR_FETCH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_address_unit #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [15:0] VECTOR_ADDR = 16'hFFFC
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    pc_address_unit_if.slave  bus
);
    localparam logic [2:0] c_PC_INC1 = 3'b001;
    localparam logic [2:0] c_PC_INC2 = 3'b010;
    localparam logic [2:0] c_PC_LOAD = 3'b011;

    logic [15:0] r_pc;
    logic [15:0] w_pc_next;
    logic [15:0] w_addr_run;
    logic [15:0] w_vec_addr;
    logic        w_busy;

    always_comb begin
        w_pc_next = r_pc;
        case (bus.pc_enable)
            c_PC_INC1: w_pc_next = r_pc + 16'd1;
            c_PC_INC2: w_pc_next = r_pc + 16'd2;
            c_PC_LOAD: w_pc_next = bus.memory_address;
            default:   w_pc_next = r_pc;
        endcase
    end

    // Zero-page indexed: carry out of the ALU byte is deliberately dropped.
    always_comb begin
        w_addr_run = r_pc;
        case (bus.address_select)
            2'd1:    w_addr_run = bus.memory_address;
            2'd2:    w_addr_run = {8'h00, bus.alu_result};
            default: w_addr_run = r_pc;
        endcase
    end

`ifdef RESET_VECTOR_FETCH_EN
    typedef enum logic [1:0] {
        S_VEC_LO = 2'd0,
        S_VEC_HI = 2'd1,
        S_RUN    = 2'd2
    } state_t;

    state_t     r_state;
    logic [7:0] r_vec_lo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_VEC_LO;
            r_vec_lo <= 8'h00;
            r_pc     <= RESET_PC;
        end else if (bus.clk_enable) begin
            case (r_state)
                S_VEC_LO: begin
                    r_vec_lo <= bus.data_in;
                    r_state  <= S_VEC_HI;
                end
                S_VEC_HI: begin
                    r_pc    <= {bus.data_in, r_vec_lo};
                    r_state <= S_RUN;
                end
                default: r_pc <= w_pc_next;
            endcase
        end
    end

    assign w_busy     = (r_state != S_RUN);
    assign w_vec_addr = (r_state == S_VEC_HI) ? (VECTOR_ADDR + 16'd1) : VECTOR_ADDR;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (bus.clk_enable) begin
            r_pc <= w_pc_next;
        end
    end

    wire w_unused_data = &{1'b0, bus.data_in};

    assign w_busy     = 1'b0;
    assign w_vec_addr = VECTOR_ADDR;
`endif

    assign bus.address_out = w_busy ? w_vec_addr : w_addr_run;
    assign bus.pc_out      = r_pc;
    assign bus.busy        = w_busy;

endmodule
`default_nettype wire
